// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the core's
// memory-access master port.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'b00,
    WR_SEND = 2'b01,
    WR_RESP = 2'b10
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_ADDR = 2'b01,
    RD_DATA = 2'b10
  } rd_state_t;

endpackage

// File: rtl/axi_lite_master_port.sv
// AXI4-Lite master bridge: turns single-beat core write/read requests into AXI
// transactions. Write and read paths are fully independent FSMs.
module axi_lite_master_port
  import axi_pkg::*;
#(
  parameter int AWIDTH = 64,
  parameter int DWIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // AXI write address / data / response
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [AWIDTH-1:0]     AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DWIDTH-1:0]     WDATA,
  output logic [DWIDTH/8-1:0]   WSTRB,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  // AXI read address / data
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [AWIDTH-1:0]     ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DWIDTH-1:0]     RDATA,
  input  logic [1:0]            RRESP,
  // core write request
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic [DWIDTH/8-1:0]   wr_strb,
  output logic                  wr_done,
  output logic [1:0]            wr_resp,
  // core read request
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [AWIDTH-1:0]     rd_addr,
  output logic                  rd_done,
  output logic [DWIDTH-1:0]     rd_data,
  output logic [1:0]            rd_resp
);

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic                awvalid_nxt, wvalid_nxt, bready_nxt, wr_done_nxt;
  logic [AWIDTH-1:0]   awaddr_nxt;
  logic [DWIDTH-1:0]   wdata_nxt;
  logic [DWIDTH/8-1:0] wstrb_nxt;
  logic [1:0]          wr_resp_nxt;

  logic                arvalid_nxt, rready_nxt, rd_done_nxt;
  logic [AWIDTH-1:0]   araddr_nxt;
  logic [DWIDTH-1:0]   rd_data_nxt;
  logic [1:0]          rd_resp_nxt;

  // A channel counts as done once its VALID has dropped or is handshaking now,
  // so AW and W may complete on the same edge or in either order.
  logic aw_done, w_done;
  assign aw_done = !AWVALID || AWREADY;
  assign w_done  = !WVALID  || WREADY;

  assign wr_req_ready = (wr_state == WR_IDLE);
  assign rd_req_ready = (rd_state == RD_IDLE);

  // ---------------- write FSM ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_req_valid)       wr_state_nxt = WR_SEND;
      WR_SEND: if (aw_done && w_done)  wr_state_nxt = WR_RESP;
      WR_RESP: if (BVALID)             wr_state_nxt = WR_IDLE;
      default:                         wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    awvalid_nxt = AWVALID;
    wvalid_nxt  = WVALID;
    bready_nxt  = BREADY;
    awaddr_nxt  = AWADDR;
    wdata_nxt   = WDATA;
    wstrb_nxt   = WSTRB;
    wr_resp_nxt = wr_resp;
    wr_done_nxt = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (wr_req_valid) begin
          awaddr_nxt  = wr_addr;
          wdata_nxt   = wr_data;
          wstrb_nxt   = wr_strb;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
        end
      end
      WR_SEND: begin
        if (AWREADY)           awvalid_nxt = 1'b0;
        if (WREADY)            wvalid_nxt  = 1'b0;
        if (aw_done && w_done) bready_nxt  = 1'b1;
      end
      WR_RESP: begin
        if (BVALID) begin
          bready_nxt  = 1'b0;
          wr_resp_nxt = BRESP;
          wr_done_nxt = 1'b1;
        end
      end
      default: begin
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        bready_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      AWADDR  <= '0;
      WDATA   <= '0;
      WSTRB   <= '0;
      wr_resp <= '0;
      wr_done <= 1'b0;
    end else begin
      AWVALID <= awvalid_nxt;
      WVALID  <= wvalid_nxt;
      BREADY  <= bready_nxt;
      AWADDR  <= awaddr_nxt;
      WDATA   <= wdata_nxt;
      WSTRB   <= wstrb_nxt;
      wr_resp <= wr_resp_nxt;
      wr_done <= wr_done_nxt;
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_req_valid) rd_state_nxt = RD_ADDR;
      RD_ADDR: if (ARREADY)      rd_state_nxt = RD_DATA;
      RD_DATA: if (RVALID)       rd_state_nxt = RD_IDLE;
      default:                   rd_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    arvalid_nxt = ARVALID;
    rready_nxt  = RREADY;
    araddr_nxt  = ARADDR;
    rd_data_nxt = rd_data;
    rd_resp_nxt = rd_resp;
    rd_done_nxt = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (rd_req_valid) begin
          araddr_nxt  = rd_addr;
          arvalid_nxt = 1'b1;
        end
      end
      RD_ADDR: begin
        if (ARREADY) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end
      end
      RD_DATA: begin
        if (RVALID) begin
          rready_nxt  = 1'b0;
          rd_data_nxt = RDATA;
          rd_resp_nxt = RRESP;
          rd_done_nxt = 1'b1;
        end
      end
      default: begin
        arvalid_nxt = 1'b0;
        rready_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      ARADDR  <= '0;
      rd_data <= '0;
      rd_resp <= '0;
      rd_done <= 1'b0;
    end else begin
      ARVALID <= arvalid_nxt;
      RREADY  <= rready_nxt;
      ARADDR  <= araddr_nxt;
      rd_data <= rd_data_nxt;
      rd_resp <= rd_resp_nxt;
      rd_done <= rd_done_nxt;
    end
  end

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Self-checking bench for axi_lite_master_port: directed scenarios plus a
// randomized transaction-level slave/core model.
module tb_axi_lite_master_port;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          ACLK, ARESET;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic          wr_req_valid, wr_req_ready, wr_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [SW-1:0] wr_strb;
  logic [1:0]    wr_resp, rd_resp;
  logic          rd_req_valid, rd_req_ready, rd_done;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_rd_data = '0;

  axi_lite_master_port #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data), .rd_resp(rd_resp)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    wr_req_valid = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
    rd_req_valid = 0; rd_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESET = 1;
    repeat (3) step();
    checks++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_done, rd_done} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000",
        {AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_done, rd_done});
    end
    checks++;
    if (AWADDR !== 0 || ARADDR !== 0 || WDATA !== 0 || WSTRB !== 0 ||
        rd_data !== 0 || wr_resp !== 0 || rd_resp !== 0) begin
      errors++; $display("FAIL reset_data: AWADDR=%h ARADDR=%h WDATA=%h WSTRB=%h rd_data=%h want all 0",
        AWADDR, ARADDR, WDATA, WSTRB, rd_data);
    end
    exp_rd_data = '0;
    ARESET = 0;
    step();
    checks++;
    if (wr_req_ready !== 1'b1 || rd_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: wr=%b rd=%b want 1 1", wr_req_ready, rd_req_ready);
    end
  endtask

  task automatic test_write_basic();
    wr_req_valid = 1; wr_addr = 64'h8000_0010; wr_data = 32'h1234_5678; wr_strb = 4'hF;
    AWREADY = 1; WREADY = 1;
    step();
    wr_req_valid = 0;
    checks++;
    if (AWVALID !== 1'b1 || WVALID !== 1'b1 || AWADDR !== 64'h8000_0010 ||
        WDATA !== 32'h1234_5678 || WSTRB !== 4'hF) begin
      errors++; $display("FAIL wr1_issue: awv=%b wv=%b addr=%h data=%h strb=%h want 1 1 80000010 12345678 f",
        AWVALID, WVALID, AWADDR, WDATA, WSTRB);
    end
    step();
    checks++;
    if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b1) begin
      errors++; $display("FAIL wr1_hs: awv=%b wv=%b bready=%b want 0 0 1", AWVALID, WVALID, BREADY);
    end
    AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00;
    step();
    BVALID = 0;
    checks++;
    if (wr_done !== 1'b1 || wr_resp !== 2'b00 || BREADY !== 1'b0 || wr_req_ready !== 1'b1) begin
      errors++; $display("FAIL wr1_done: done=%b resp=%b bready=%b ready=%b want 1 00 0 1",
        wr_done, wr_resp, BREADY, wr_req_ready);
    end
    step();
    checks++;
    if (wr_done !== 1'b0) begin
      errors++; $display("FAIL wr1_pulse: wr_done=%b want 0", wr_done);
    end
  endtask

  task automatic test_write_skewed();
    wr_req_valid = 1; wr_addr = 64'h0000_1234_0000_0040; wr_data = 32'hCAFE_F00D; wr_strb = 4'h3;
    step();
    wr_req_valid = 0;
    AWREADY = 1;
    step();
    AWREADY = 0;
    checks++;
    if (AWVALID !== 1'b0 || WVALID !== 1'b1 || BREADY !== 1'b0) begin
      errors++; $display("FAIL wr2_aw: awv=%b wv=%b bready=%b want 0 1 0", AWVALID, WVALID, BREADY);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (WVALID !== 1'b1 || WDATA !== 32'hCAFE_F00D || WSTRB !== 4'h3 || BREADY !== 1'b0) begin
        errors++; $display("FAIL wr2_wait: wv=%b data=%h strb=%h bready=%b want 1 cafef00d 3 0",
          WVALID, WDATA, WSTRB, BREADY);
      end
    end
    WREADY = 1;
    step();
    WREADY = 0;
    checks++;
    if (WVALID !== 1'b0 || BREADY !== 1'b1) begin
      errors++; $display("FAIL wr2_w: wv=%b bready=%b want 0 1", WVALID, BREADY);
    end
    BVALID = 1; BRESP = 2'b01;
    step();
    BVALID = 0;
    checks++;
    if (wr_done !== 1'b1 || wr_resp !== 2'b01) begin
      errors++; $display("FAIL wr2_done: done=%b resp=%b want 1 01", wr_done, wr_resp);
    end
  endtask

  task automatic test_read_delayed();
    rd_req_valid = 1; rd_addr = 64'h8000_0000;
    step();
    rd_req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ARVALID !== 1'b1 || ARADDR !== 64'h8000_0000 || rd_req_ready !== 1'b0) begin
        errors++; $display("FAIL rd_ar_wait: arv=%b araddr=%h ready=%b want 1 80000000 0",
          ARVALID, ARADDR, rd_req_ready);
      end
      step();
    end
    ARREADY = 1;
    step();
    ARREADY = 0;
    checks++;
    if (ARVALID !== 1'b0 || RREADY !== 1'b1) begin
      errors++; $display("FAIL rd_ar_hs: arv=%b rready=%b want 0 1", ARVALID, RREADY);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (rd_done !== 1'b0 || RREADY !== 1'b1) begin
        errors++; $display("FAIL rd_r_wait: done=%b rready=%b want 0 1", rd_done, RREADY);
      end
    end
    RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00;
    step();
    RVALID = 0; RDATA = 0;
    exp_rd_data = 32'hDEAD_BEEF;
    checks++;
    if (rd_done !== 1'b1 || rd_data !== 32'hDEAD_BEEF || rd_resp !== 2'b00 || RREADY !== 1'b0) begin
      errors++; $display("FAIL rd_done: done=%b data=%h resp=%b rready=%b want 1 deadbeef 00 0",
        rd_done, rd_data, rd_resp, RREADY);
    end
    step();
    checks++;
    if (rd_done !== 1'b0 || rd_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_hold: done=%b data=%h want 0 deadbeef", rd_done, rd_data);
    end
  endtask

  task automatic test_simultaneous();
    wr_req_valid = 1; wr_addr = 64'h10; wr_data = 32'h5555_AAAA; wr_strb = 4'h8;
    rd_req_valid = 1; rd_addr = 64'h20;
    checks++;
    if (wr_req_ready !== 1'b1 || rd_req_ready !== 1'b1) begin
      errors++; $display("FAIL sim_ready: wr=%b rd=%b want 1 1", wr_req_ready, rd_req_ready);
    end
    step();
    wr_req_valid = 0; rd_req_valid = 0;
    checks++;
    if (AWVALID !== 1'b1 || WVALID !== 1'b1 || ARVALID !== 1'b1) begin
      errors++; $display("FAIL sim_valid: awv=%b wv=%b arv=%b want 1 1 1", AWVALID, WVALID, ARVALID);
    end
    AWREADY = 1; WREADY = 1; ARREADY = 1;
    step();
    AWREADY = 0; WREADY = 0; ARREADY = 0;
    BVALID = 1; BRESP = 2'b00; RVALID = 1; RDATA = 32'h0BAD_F00D; RRESP = 2'b00;
    step();
    BVALID = 0; RVALID = 0;
    exp_rd_data = 32'h0BAD_F00D;
    checks++;
    if (wr_done !== 1'b1 || rd_done !== 1'b1 || rd_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL sim_done: wr_done=%b rd_done=%b data=%h want 1 1 0badf00d",
        wr_done, rd_done, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    wr_req_valid = 1; wr_addr = 64'h100; wr_data = 32'h1; wr_strb = 4'hF;
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b00;
    for (int c = 0; c < 12; c++) begin
      if (wr_req_ready) acc_cyc.push_back(c);
      step();
      wr_data = wr_data + 1;
    end
    wr_req_valid = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
    repeat (3) step();
    checks++;
    if (acc_cyc.size() != 4) begin
      errors++; $display("FAIL b2b_count: accepts=%0d want 4", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
        errors++; $display("FAIL b2b_spacing: gap=%0d want 3", acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    wr_req_valid = 1; wr_addr = 64'hFFFF_0000_0000_0008; wr_data = 32'h7777_7777; wr_strb = 4'hF;
    step();
    wr_req_valid = 0;
    #2 ARESET = 1;
    #1;
    checks++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_done, rd_done} !== 7'b0 ||
        AWADDR !== 0 || WDATA !== 0 || WSTRB !== 0 || rd_data !== 0) begin
      errors++; $display("FAIL rst_mid: ctrl=%b awaddr=%h wdata=%h want all 0",
        {AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_done, rd_done}, AWADDR, WDATA);
    end
    exp_rd_data = '0;
    BVALID = 1;
    step();
    ARESET = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (wr_done !== 1'b0 || BREADY !== 1'b0 || wr_req_ready !== 1'b1) begin
        errors++; $display("FAIL rst_nodone: done=%b bready=%b ready=%b want 0 0 1",
          wr_done, BREADY, wr_req_ready);
      end
    end
    BVALID = 0;
    wr_req_valid = 1; wr_addr = 64'h44; wr_data = 32'h9; wr_strb = 4'h1;
    AWREADY = 1; WREADY = 1;
    step();
    wr_req_valid = 0;
    step();
    AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00;
    step();
    BVALID = 0;
    checks++;
    if (wr_done !== 1'b1 || wr_resp !== 2'b00) begin
      errors++; $display("FAIL rst_after: done=%b resp=%b want 1 00", wr_done, wr_resp);
    end
    step();
  endtask

  // Randomized traffic: a core model issuing requests and a slave model with
  // random back-pressure; every write/read is matched against what was issued.
  task automatic test_random(input int nwr, input int nrd, input bit fix,
                             input logic [1:0] fb, input logic [1:0] fr, input int pct);
    logic [AW-1:0] wq_a[$];
    logic [DW-1:0] wq_d[$];
    logic [SW-1:0] wq_s[$];
    logic [AW-1:0] rq_a[$];
    int wr_acc = 0, wr_cmp = 0, rd_acc = 0, rd_cmp = 0;
    bit core_done = 0;
    fork
      begin
        int wi = 0, ri = 0, cyc = 0;
        while ((wi < nwr || ri < nrd || wr_req_valid || rd_req_valid) && cyc < 8000) begin
          bit acc_w, acc_r;
          if (!wr_req_valid && wi < nwr && $urandom_range(0, 99) < 50) begin
            wr_addr = {$urandom, $urandom}; wr_data = $urandom; wr_strb = SW'($urandom);
            wr_req_valid = 1; wi++;
          end
          if (!rd_req_valid && ri < nrd && $urandom_range(0, 99) < 50) begin
            rd_addr = {$urandom, $urandom}; rd_req_valid = 1; ri++;
          end
          acc_w = wr_req_valid && wr_req_ready;
          acc_r = rd_req_valid && rd_req_ready;
          if (acc_w) begin wq_a.push_back(wr_addr); wq_d.push_back(wr_data); wq_s.push_back(wr_strb); wr_acc++; end
          if (acc_r) begin rq_a.push_back(rd_addr); rd_acc++; end
          step();
          cyc++;
          if (acc_w) wr_req_valid = 0;
          if (acc_r) rd_req_valid = 0;
        end
        core_done = 1;
      end
      begin
        bit aw_seen = 0, w_seen = 0, bpend = 0, rpend = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
          bit hs_aw, hs_w, hs_ar, hs_b, hs_r, st_aw, st_w, st_ar;
          logic [AW-1:0] sv_aw, sv_ar;
          logic [DW-1:0] sv_wd, r_val;
          logic [SW-1:0] sv_ws;
          logic [1:0] b_val, rr_val;
          if (core_done && wr_cmp == wr_acc && rd_cmp == rd_acc) break;
          AWREADY = ($urandom_range(0, 99) < pct);
          WREADY  = ($urandom_range(0, 99) < pct);
          ARREADY = ($urandom_range(0, 99) < pct);
          if (!BVALID && bpend && $urandom_range(0, 99) < pct) begin
            BVALID = 1; BRESP = fix ? fb : 2'($urandom);
          end
          if (!RVALID && rpend && $urandom_range(0, 99) < pct) begin
            RVALID = 1; RDATA = $urandom; RRESP = fix ? fr : 2'($urandom);
          end
          hs_aw = AWVALID && AWREADY; hs_w = WVALID && WREADY; hs_ar = ARVALID && ARREADY;
          hs_b = BVALID && BREADY;    hs_r = RVALID && RREADY;
          st_aw = AWVALID && !AWREADY; st_w = WVALID && !WREADY; st_ar = ARVALID && !ARREADY;
          sv_aw = AWADDR; sv_wd = WDATA; sv_ws = WSTRB; sv_ar = ARADDR;
          b_val = BRESP; r_val = RDATA; rr_val = RRESP;
          if (hs_aw) begin
            checks++;
            if (wq_a.size() == 0 || AWADDR !== wq_a[0]) begin
              errors++; $display("FAIL rnd_awaddr: got %h want %h", AWADDR, wq_a.size() ? wq_a[0] : '0);
            end
          end
          if (hs_w) begin
            checks++;
            if (wq_d.size() == 0 || WDATA !== wq_d[0] || WSTRB !== wq_s[0]) begin
              errors++; $display("FAIL rnd_wdata: got %h/%h want %h/%h", WDATA, WSTRB,
                wq_d.size() ? wq_d[0] : '0, wq_s.size() ? wq_s[0] : '0);
            end
          end
          if (hs_ar) begin
            checks++;
            if (rq_a.size() == 0 || ARADDR !== rq_a[0]) begin
              errors++; $display("FAIL rnd_araddr: got %h want %h", ARADDR, rq_a.size() ? rq_a[0] : '0);
            end
          end
          step();
          if (st_aw || st_w || st_ar) begin
            checks++;
            if ((st_aw && (AWVALID !== 1'b1 || AWADDR !== sv_aw)) ||
                (st_w && (WVALID !== 1'b1 || WDATA !== sv_wd || WSTRB !== sv_ws)) ||
                (st_ar && (ARVALID !== 1'b1 || ARADDR !== sv_ar))) begin
              errors++; $display("FAIL rnd_stable: awv=%b wv=%b arv=%b held payload changed or valid dropped",
                AWVALID, WVALID, ARVALID);
            end
          end
          if (hs_aw) aw_seen = 1;
          if (hs_w)  w_seen = 1;
          if (aw_seen && w_seen) begin
            aw_seen = 0; w_seen = 0; bpend = 1;
            void'(wq_a.pop_front()); void'(wq_d.pop_front()); void'(wq_s.pop_front());
          end
          if (hs_ar) begin void'(rq_a.pop_front()); rpend = 1; end
          checks++;
          if (wr_done !== hs_b || (hs_b && wr_resp !== b_val)) begin
            errors++; $display("FAIL rnd_wr_done: done=%b resp=%b want %b %b", wr_done, wr_resp, hs_b, b_val);
          end
          if (hs_b) begin BVALID = 0; bpend = 0; wr_cmp++; end
          if (hs_r) exp_rd_data = r_val;
          checks++;
          if (rd_done !== hs_r || rd_data !== exp_rd_data || (hs_r && rd_resp !== rr_val)) begin
            errors++; $display("FAIL rnd_rd_done: done=%b data=%h resp=%b want %b %h %b",
              rd_done, rd_data, rd_resp, hs_r, exp_rd_data, rr_val);
          end
          if (hs_r) begin RVALID = 0; rpend = 0; rd_cmp++; end
        end
        AWREADY = 0; WREADY = 0; ARREADY = 0;
      end
    join
    checks++;
    if (!core_done || wr_acc != nwr || rd_acc != nrd || wr_cmp != wr_acc || rd_cmp != rd_acc) begin
      errors++; $display("FAIL rnd_complete: wr %0d/%0d/%0d rd %0d/%0d/%0d (issued/accepted/done)",
        nwr, wr_acc, wr_cmp, nrd, rd_acc, rd_cmp);
    end
  endtask

  task automatic test_error_resp();
    test_random(1, 1, 1'b1, 2'b10, 2'b11, 70);
    checks++;
    if (wr_resp !== 2'b10 || rd_resp !== 2'b11 || wr_req_ready !== 1'b1 || rd_req_ready !== 1'b1) begin
      errors++; $display("FAIL err_resp: wr_resp=%b rd_resp=%b wr_rdy=%b rd_rdy=%b want 10 11 1 1",
        wr_resp, rd_resp, wr_req_ready, rd_req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_skewed();
    test_read_delayed();
    test_error_resp();
    test_simultaneous();
    test_back_to_back();
    test_reset_midflight();
    test_random(40, 40, 1'b0, 2'b00, 2'b00, 50);
    test_random(30, 30, 1'b0, 2'b00, 2'b00, 100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
